hsstl_rst4mcrsw_rate_chg_ctrl: RTL

Sequences a PCIe Gen1/Gen2 rate change between the MAC and the HSST reset FSMs. It filters the MAC rate request and drives a single rate level to both the TX and RX reset FSMs. It then collects their rate-done acknowledgements and returns a one-cycle phystatus pulse to the MAC. It also covers the link-down case, a timeout case and a sticky error flag.

---
 rtl/hsstl_rst4mcrsw_rate_chg_ctrl_pkg.sv | 23 ++
 rtl/hsstl_rst4mcrsw_sync2ff.sv | 12 +
 rtl/hsstl_rst4mcrsw_rate_chg_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/hsstl_rst4mcrsw_rate_chg_ctrl_pkg.sv
// hsstl_rst4mcrsw_rate_chg_ctrl_pkg: shared encodings and defaults for the PCIe rate-change controller
package hsstl_rst4mcrsw_rate_chg_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STABLE    = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_STATUS    = 3'd4,
    ST_DIRECT    = 3'd5
  } ctrl_state_e;
  // RX reset FSM states, common with the RX reset FSM
  localparam logic [3:0] RX_IDLE     = 4'd0;
  localparam logic [3:0] RX_RST_DONE = 4'd6;
  localparam logic [3:0] RX_RECOVERY = 4'd7;
  localparam logic [3:0] RX_CKDIV    = 4'd8;
  localparam int DEF_STABLE_CNT = 8;
`ifdef IPSL_PCIE_SPEEDUP_SIM
  localparam int DEF_TIMEOUT_CNT = 2048;
`else
  // must exceed the 32768-cycle RX CKDIV window
  localparam int DEF_TIMEOUT_CNT = 40000;
`endif
endpackage

// File: rtl/hsstl_rst4mcrsw_sync2ff.sv
// hsstl_rst4mcrsw_sync2ff: generic two-flop bit synchroniser
module hsstl_rst4mcrsw_sync2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/hsstl_rst4mcrsw_rate_chg_ctrl.sv
// hsstl_rst4mcrsw_rate_chg_ctrl: filters the MAC rate request, drives the TX/RX reset FSMs
// and returns a one-cycle phystatus once both rate-done acknowledgements (or a timeout) arrive
module hsstl_rst4mcrsw_rate_chg_ctrl
  import hsstl_rst4mcrsw_rate_chg_ctrl_pkg::*;
#(
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int TIMEOUT_CNT = DEF_TIMEOUT_CNT,
  parameter int CNTR_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mac_rate,
  input  logic [3:0] rx_main_fsm,
  input  logic       tx_rate_done,
  input  logic       rx_rate_done,
  output logic       rate,
  output logic       phystatus,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] ctrl_state
);
  localparam logic [3:0] STAB_LAST = 4'(STABLE_CNT - 1);
  localparam logic [CNTR_WIDTH-1:0] TO_LAST = CNTR_WIDTH'(TIMEOUT_CNT - 1);
  ctrl_state_e state, state_nxt;
  logic [3:0] stab_cnt, stab_nxt;
  logic [CNTR_WIDTH-1:0] to_cnt, to_nxt;
  logic tx_seen, tx_nxt, rx_seen, rx_nxt, rate_nxt, terr_nxt, rs;

  hsstl_rst4mcrsw_sync2ff u_sync_rate (.clk(clk), .rst_n(rst_n), .d(mac_rate), .q(rs));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= ST_IDLE;
      stab_cnt    <= '0;
      to_cnt      <= '0;
      tx_seen     <= 1'b0;
      rx_seen     <= 1'b0;
      rate        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      stab_cnt    <= stab_nxt;
      to_cnt      <= to_nxt;
      tx_seen     <= tx_nxt;
      rx_seen     <= rx_nxt;
      rate        <= rate_nxt;
      timeout_err <= terr_nxt;
    end

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    to_nxt    = to_cnt;
    tx_nxt    = tx_seen;
    rx_nxt    = rx_seen;
    rate_nxt  = rate;
    terr_nxt  = timeout_err;
    case (state)
      ST_IDLE:
        if (rs != rate) begin
          state_nxt = ST_STABLE;
          stab_nxt  = '0;
        end
      ST_STABLE:
        if (rs == rate) state_nxt = ST_IDLE;
        else begin
          stab_nxt = 4'(stab_cnt + 1);
          // an RX FSM still in IDLE samples rate on its own, so no handshake is needed
          if (stab_cnt == STAB_LAST) state_nxt = (rx_main_fsm == RX_IDLE) ? ST_DIRECT : ST_ISSUE;
        end
      ST_ISSUE: begin
        rate_nxt  = rs;
        tx_nxt    = 1'b0;
        rx_nxt    = 1'b0;
        to_nxt    = '0;
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tx_nxt = tx_seen | tx_rate_done;
        rx_nxt = rx_seen | rx_rate_done;
        to_nxt = CNTR_WIDTH'(to_cnt + 1);
        // a done arriving on the timeout cycle wins and leaves timeout_err clear
        if (tx_nxt && rx_nxt) state_nxt = ST_STATUS;
        else if (to_cnt == TO_LAST) begin
          state_nxt = ST_STATUS;
          terr_nxt  = 1'b1;
        end
      end
      ST_DIRECT: begin
        rate_nxt  = rs;
        state_nxt = ST_STATUS;
      end
      ST_STATUS: state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        stab_nxt  = '0;
        to_nxt    = '0;
        tx_nxt    = 1'b0;
        rx_nxt    = 1'b0;
      end
    endcase
  end

  assign phystatus  = state == ST_STATUS;
  assign busy       = state inside {ST_ISSUE, ST_WAIT_DONE, ST_DIRECT, ST_STATUS};
  assign ctrl_state = state;
endmodule
